ysyx_24120009_mem_arbiter: RTL
==============================

// Module: ysyx_24120009_mem_arbiter
// PURPOSE
//  2-master / 1-slave round-robin arbiter sharing the single data-memory port between IFU (m0) and LSU/MEM (m1).
//  Latches the granted request, drives it to memory with a valid/ready handshake, and routes the response to its owner.
//  A watchdog aborts hung transactions with an error response. Sits between the IFU/MEM stages and the memory model/bus.
// PARAMETERS
//  ADDR_W          32   address width
//  DATA_W          32   data width; wmask width = DATA_W/8
//  TIMEOUT_CYCLES  255  max cycles from issue to response before abort; 0 = watchdog disabled
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         asynchronous reset, active-high
//  mN_req_valid  in   1         N=0 (IFU), 1 (LSU): request valid
//  mN_req_ready  out  1         request accepted this cycle
//  mN_addr       in   ADDR_W    request address
//  mN_wen        in   1         1 = write, 0 = read
//  mN_wdata      in   DATA_W    write data
//  mN_wmask      in   DATA_W/8  byte write mask
//  mN_rsp_valid  out  1         one-cycle response pulse (master always accepts)
//  mN_rsp_data   out  DATA_W    read data; 0 on writes and errors
//  mN_rsp_err    out  1         1 = slave error or timeout
//  s_req_valid   out  1         request to memory
//  s_req_ready   in   1         memory accepts request
//  s_addr/s_wen/s_wdata/s_wmask  out  as mN_*  latched request payload
//  s_rsp_valid   in   1         memory response valid (single cycle)
//  s_rsp_data    in   DATA_W    memory read data
//  s_rsp_err     in   1         memory error
//  owner         out  1         current/last granted master
//  busy          out  1         state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, prio=0 (m0 wins first tie), owner=0, all valids/ready/err 0, payload regs and data 0, counter 0.
//  States: IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE: mN_req_ready is combinational = grant; single requester always granted; both -> prio master.
//   On grant: latch addr/wen/wdata/wmask, owner<=N, prio<=~N, cnt<=0, -> ISSUE. No grant -> stay.
//  ISSUE: s_req_valid=1, payload stable. s_req_ready -> WAIT. Both mN_req_ready=0 in ISSUE and WAIT.
//  WAIT: s_rsp_valid -> owner rsp_valid=1 next cycle (registered) with s_rsp_data/s_rsp_err; -> IDLE.
//   s_rsp_valid in same cycle as s_req_ready (ISSUE) is ignored; slave must respond >=1 cycle after accept.
//  Watchdog: cnt increments each cycle in ISSUE/WAIT, saturates. If TIMEOUT_CYCLES!=0 and cnt==TIMEOUT_CYCLES-1
//   with no s_req_ready (ISSUE) / s_rsp_valid (WAIT) that cycle: owner rsp_valid=1, err=1, data=0 next cycle; -> IDLE.
//   Handshake/response in the timeout cycle wins over abort. ISSUE abort drops s_req_valid without handshake.
//  Late s_rsp_valid while IDLE/ISSUE is dropped silently.
//  Latency: accept at T, s_req_valid from T+1; ready at T+1, rsp at T+2 -> mN_rsp_valid at T+3 (minimum 3).
//   Arbiter is IDLE in T+3 and may grant a new request in the same cycle as the rsp pulse.
//  rsp outputs other than owner's held 0; rsp_valid is exactly one cycle per accepted request.
//  Async rst mid-transaction: immediate return to reset values; in-flight transaction lost, no response pulse.
// STRUCTURE
//  ysyx_24120009_defs.vh: state encoding macros (ARB_IDLE/ISSUE/WAIT), master IDs (ARB_M_IFU=0, ARB_M_LSU=1).
//  Sub-module ysyx_24120009_rr_arb2: 2-way grant picker + prio pointer register (update on accept).
//  Payload hold regs via existing ysyx_24120009_Reg with wen = grant.
// TESTING
//  m0 read alone, s_req_ready at T+1, s_rsp_data=0xDEADBEEF at T+2 -> m0_rsp_valid at T+3, data 0xDEADBEEF, err 0.
//  m0,m1 request same cycle after reset -> m0 granted; both re-request -> m1 next, then m0 (strict alternation).
//  m1 write addr 0x80000010 wdata 0x12345678 mask 0xF, s_req_ready held 0 for 5 cycles -> s_* stable, valid held.
//  TIMEOUT_CYCLES=4, no s_rsp_valid -> owner rsp_valid err=1 data=0 at 5th cycle after ISSUE entry; busy=0 after.
//  s_rsp_valid exactly in timeout cycle -> normal response (err=s_rsp_err), no extra error pulse.
//  rst pulse in WAIT -> busy=0, s_req_valid=0, no rsp pulse; late s_rsp_valid after reset ignored; next m1 req granted.

Source files
------------

// File: rtl/ysyx_24120009_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states, master IDs
// and watchdog counter sizing.
package ysyx_24120009_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam logic ARB_M_IFU = 1'b0;
    localparam logic ARB_M_LSU = 1'b1;

    // Counter only ever needs to reach TIMEOUT_CYCLES-1; keep at least one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/ysyx_24120009_rr_arb2.sv
// Two-way round-robin grant picker; the priority pointer moves past the
// winner whenever a grant is issued.
module ysyx_24120009_rr_arb2
    import ysyx_24120009_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       winner
);

    logic prio;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            prio <= ARB_M_IFU;
        end else if (|grant) begin
            prio <= ~winner;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        grant  = 2'b00;
        winner = ARB_M_IFU;
        if (en) begin
            unique case (req)
                2'b01: begin
                    grant  = 2'b01;
                    winner = ARB_M_IFU;
                end
                2'b10: begin
                    grant  = 2'b10;
                    winner = ARB_M_LSU;
                end
                2'b11: begin
                    grant  = prio ? 2'b10 : 2'b01;
                    winner = prio;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_24120009_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU (m0) and LSU (m1),
// with a latched request payload, registered responses and a hang watchdog.
module ysyx_24120009_mem_arbiter
    import ysyx_24120009_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_wen,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    output logic                m0_rsp_valid,
    output logic [DATA_W-1:0]   m0_rsp_data,
    output logic                m0_rsp_err,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_wen,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_rsp_valid,
    output logic [DATA_W-1:0]   m1_rsp_data,
    output logic                m1_rsp_err,

    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic                s_wen,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wmask,
    input  logic                s_rsp_valid,
    input  logic [DATA_W-1:0]   s_rsp_data,
    input  logic                s_rsp_err,

    output logic                owner,
    output logic                busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    arb_state_e state_q, state_d;

    logic [1:0]        grant;
    logic              winner;

    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              owner_q;

    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              timeout;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    ysyx_24120009_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == ARB_IDLE),
        .req    ({m1_req_valid, m0_req_valid}),
        .grant  (grant),
        .winner (winner)
    );

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign timeout = WDOG_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (|grant) begin
                    state_d = ARB_ISSUE;
                    cnt_d   = '0;
                end
            end
            ARB_ISSUE: begin
                cnt_d = cnt_inc;
                // A handshake in the timeout cycle takes precedence over the abort.
                if (s_req_ready) begin
                    state_d = ARB_WAIT;
                end else if (timeout) begin
                    state_d     = ARB_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_inc;
                if (s_rsp_valid) begin
                    state_d     = ARB_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = s_rsp_err;
                    rsp_data_d  = (s_rsp_err || wen_q) ? '0 : s_rsp_data;
                end else if (timeout) begin
                    state_d     = ARB_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: payload regs drive s_* directly, so they are reset to keep the memory port clean after reset.
        if (rst) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            owner_q <= ARB_M_IFU;
        end else if (|grant) begin
            addr_q  <= winner ? m1_addr  : m0_addr;
            wen_q   <= winner ? m1_wen   : m0_wen;
            wdata_q <= winner ? m1_wdata : m0_wdata;
            wmask_q <= winner ? m1_wmask : m0_wmask;
            owner_q <= winner;
        end
    end

    assign m0_req_ready = grant[0];
    assign m1_req_ready = grant[1];

    assign s_req_valid = (state_q == ARB_ISSUE);
    assign s_addr      = addr_q;
    assign s_wen       = wen_q;
    assign s_wdata     = wdata_q;
    assign s_wmask     = wmask_q;

    // owner_q only changes on the edge after a grant, so it still names the
    // responder during a pulse that overlaps a new grant.
    assign m0_rsp_valid = rsp_valid_q && (owner_q == ARB_M_IFU);
    assign m0_rsp_data  = (owner_q == ARB_M_IFU) ? rsp_data_q : '0;
    assign m0_rsp_err   = rsp_err_q && (owner_q == ARB_M_IFU);
    assign m1_rsp_valid = rsp_valid_q && (owner_q == ARB_M_LSU);
    assign m1_rsp_data  = (owner_q == ARB_M_LSU) ? rsp_data_q : '0;
    assign m1_rsp_err   = rsp_err_q && (owner_q == ARB_M_LSU);

    assign owner = owner_q;
    assign busy  = (state_q != ARB_IDLE);

endmodule
